// File: rtl/switch_arbiter.sv
// Round-robin scheduler for the 8x8 single-transfer switch fabric.
// Ports: clk, rst (sync, high), en, req[8], addr[8][4], full[8] in; grant, pop, drop_cnt out.
module switch_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       req,
  input  logic [3:0]       addr [7:0],
  input  logic [7:0]       full,
  output logic [7:0]       grant,
  output logic [7:0]       pop,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [7:0]       grant_d, grant_q;
  logic [2:0]       ptr_d, ptr_q;
  logic             last_vld_d, last_vld_q;
  logic [2:0]       last_dst_d, last_dst_q;
  logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

  logic [7:0] ok;
  logic [7:0] elig;
  logic [7:0] inv;
  logic [2:0] idx;
  logic [2:0] win;
  logic       found;
  logic       drop_hit;

  always_comb begin
    ok   = '0;
    elig = '0;
    inv  = '0;
    for (int i = 0; i < 8; i++) begin
      inv[i] = addr[i][3];
      // last_dst covers the cycle before full reflects our own push
      ok[i] = addr[i][3]
            | (~full[addr[i][2:0]]
               & ~(last_vld_q & (last_dst_q == addr[i][2:0])));
      elig[i] = req[i] & ~grant_q[i] & ok[i];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign drop_hit = |(grant_q & inv);

  always_comb begin
    grant_d    = '0;
    ptr_d      = ptr_q;
    last_vld_d = 1'b0;
    last_dst_d = last_dst_q;
    drop_cnt_d = drop_cnt_q;
    if (en && found) begin
      grant_d    = 8'd1 << win;
      ptr_d      = win + 3'd1;
      last_vld_d = ~addr[win][3];
      last_dst_d = addr[win][2:0];
    end
    if (drop_hit && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      ptr_q      <= '0;
      last_vld_q <= 1'b0;
      last_dst_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      last_vld_q <= last_vld_d;
      last_dst_q <= last_dst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign pop      = grant_q;
  assign drop_cnt = drop_cnt_q;

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(grant_q));

  a_pop: assert property (
    @(posedge clk) pop == grant);

  // a granted FIFO must still hold its head until the pop lands
  a_req: assert property (
    @(posedge clk) disable iff (rst) (grant_q & ~req) == 8'd0);

  for (genvar g = 0; g < 8; g++) begin : g_chk
    a_full: assert property (
      @(posedge clk) disable iff (rst)
      (grant_d[g] && !addr[g][3]) |-> !full[addr[g][2:0]]);
  end
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter.
// Table vectors plus hand sequences for backpressure and enable/reset.
module tb_switch_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  req;
  logic [3:0]  addr [7:0];
  logic [7:0]  full;
  logic [7:0]  grant;
  logic [7:0]  pop;
  logic [15:0] drop_cnt;
  logic [7:0]  grant2;
  logic [7:0]  pop2;
  logic [1:0]  drop_cnt2;

  int tests;
  int failed;

  switch_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .addr(addr), .full(full), .grant(grant),
    .pop(pop), .drop_cnt(drop_cnt)
  );

  switch_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .addr(addr), .full(full), .grant(grant2),
    .pop(pop2), .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  req;
    logic [7:0]  full;
    logic [31:0] addr;
    logic [7:0]  g;
    int          d;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] A_ID = 32'h7654_3210;

  function automatic void add(
    input logic r, input logic e,
    input logic [7:0] rq, input logic [7:0] fl,
    input logic [31:0] ad, input logic [7:0] g,
    input int d);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.full = fl;
    v.addr = ad; v.g = g; v.d = d;
    vq.push_back(v);
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] ad);
    for (int i = 0; i < 8; i++) addr[i] = ad[4*i +: 4];
  endtask

  int n;
  int d2;

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1; en = 1'b0; req = '0; full = '0;
    set_addr('0);

    // 1: reset then idle
    add(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    for (int k = 0; k < 10; k++)
      add(0, 1, 8'h00, 8'h00, 0, 8'h00, 0);

    // 2: round-robin over all inputs, distinct destinations
    for (int k = 0; k < 16; k++)
      add(0, 1, 8'hFF, 8'h00, A_ID, 8'(8'd1 << (k % 8)), 0);
    add(1, 1, 8'hFF, 8'h00, A_ID, 8'h00, 0);

    // 3: two inputs sharing destination 5
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h01, 0);
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h00, 0);
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h02, 0);
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h00, 0);
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h01, 0);
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h00, 0);
    add(0, 1, 8'h03, 8'h00, 32'h55, 8'h02, 0);
    add(1, 1, 8'h03, 8'h00, 32'h55, 8'h00, 0);

    // 5: drop path with all outputs full; 5 drops total
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h04, 0);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h00, 1);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h04, 1);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h00, 2);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h04, 2);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h00, 3);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h04, 3);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h00, 4);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h04, 4);
    add(0, 1, 8'h04, 8'hFF, 32'hC00, 8'h00, 5);
    add(0, 1, 8'h00, 8'hFF, 32'hC00, 8'h00, 5);
    add(1, 1, 8'h00, 8'h00, 32'h0,   8'h00, 0);

    foreach (vq[j]) begin
      rst  = vq[j].rst;
      en   = vq[j].en;
      req  = vq[j].req;
      full = vq[j].full;
      set_addr(vq[j].addr);
      step();
      check($sformatf("v%0d grant", j), 32'(grant), 32'(vq[j].g));
      check($sformatf("v%0d pop", j), 32'(pop), 32'(vq[j].g));
      check($sformatf("v%0d drop", j), 32'(drop_cnt), 32'(vq[j].d));
      d2 = (vq[j].d > 3) ? 3 : vq[j].d;
      check($sformatf("v%0d drop_sat", j), 32'(drop_cnt2), 32'(d2));
    end

    // 4: backpressure on destination 3, then release
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1; req = 8'h01; full = 8'h08;
    set_addr(32'h3);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp hold%0d", k), 32'(grant), 32'h0);
    end
    full = 8'h00;
    n = 0;
    do begin
      step();
      n++;
    end while (grant == 8'h00 && n < 4);
    check("bp latency", 32'(n), 32'd1);
    check("bp grant", 32'(grant), 32'h01);
    step();
    check("bp after", 32'(grant), 32'h00);

    // 6: enable drop resumes at ptr, reset mid-grant
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1; req = 8'hFF; full = 8'h00;
    set_addr(A_ID);
    step();
    check("en g01", 32'(grant), 32'h01);
    step();
    check("en g02", 32'(grant), 32'h02);
    en = 1'b0;
    step();
    check("en off0", 32'(grant), 32'h00);
    step();
    check("en off1", 32'(grant), 32'h00);
    en = 1'b1;
    step();
    check("en resume", 32'(grant), 32'h04);
    step();
    check("en g08", 32'(grant), 32'h08);
    rst = 1'b1;
    step();
    check("rst grant", 32'(grant), 32'h00);
    check("rst pop", 32'(pop), 32'h00);
    check("rst drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0;
    step();
    check("rst ptr", 32'(grant), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
